// File: rtl/branch_redirect_unit_pkg.sv
// Shared types and defaults for the branch redirect unit.
// Holds the BPU training record layout and the redirect FSM encoding.
package branch_redirect_unit_pkg;

  localparam int BRU_ADDR_W     = 32;
  localparam int BRU_INST_BYTES = 4;
  localparam int BRU_CNT_W      = 32;

  typedef enum logic [0:0] {
    RS_IDLE    = 1'b0,
    RS_PENDING = 1'b1
  } redirect_state_e;

  // Flattened onto bpu_upd_o MSB-first in this field order.
  typedef struct packed {
    logic [BRU_ADDR_W-1:0] pc;
    logic                  taken;
    logic [BRU_ADDR_W-1:0] target;
    logic                  mispredict;
  } branch_update_t;

endpackage

// File: rtl/branch_redirect_unit_perf_counter.sv
// Free-running event counter: increments on inc, wraps at 2^CNT_W.
// One-cycle update latency; synchronous clear on rst.
module branch_redirect_unit_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Resolves EX-stage branches against the frontend prediction: flush pulse, held redirect,
// BPU training pulse and perf counters. Accept->redirect latency is one cycle.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter int ADDR_W     = BRU_ADDR_W,
  parameter int INST_BYTES = BRU_INST_BYTES,
  parameter int CNT_W      = BRU_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid_i,
  input  logic                ex_is_branch_i,
  input  logic [ADDR_W-1:0]   ex_pc_i,
  input  logic                ex_taken_i,
  input  logic [ADDR_W-1:0]   ex_target_i,
  input  logic                pred_taken_i,
  input  logic [ADDR_W-1:0]   pred_target_i,
  input  logic                excp_flush_i,
  input  logic                redirect_ready_i,
  output logic                redirect_valid_o,
  output logic [ADDR_W-1:0]   redirect_pc_o,
  output logic                backend_flush_o,
  output logic                ex_stall_o,
  output logic                bpu_upd_valid_o,
  output logic [2*ADDR_W+1:0] bpu_upd_o,
  output logic [CNT_W-1:0]    perf_branch_cnt_o,
  output logic [CNT_W-1:0]    perf_mispred_cnt_o
);

  redirect_state_e state_q, state_d;

  logic              accept;
  logic              mispredict;
  logic              fire;
  logic [ADDR_W-1:0] correct_pc;

  logic [ADDR_W-1:0] upd_pc_q;
  logic              upd_taken_q;
  logic [ADDR_W-1:0] upd_target_q;
  logic              upd_mispredict_q;

  // A commit-stage exception kills whatever sits in EX this cycle.
  assign accept     = ex_valid_i & ex_is_branch_i & (state_q == RS_IDLE) & ~excp_flush_i;
  assign mispredict = (pred_taken_i != ex_taken_i) |
                      (ex_taken_i & (pred_target_i != ex_target_i));
  assign correct_pc = ex_taken_i ? ex_target_i : (ex_pc_i + ADDR_W'(INST_BYTES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (excp_flush_i) begin
      state_d = RS_IDLE;
    end else begin
      case (state_q)
        RS_IDLE:    if (accept && mispredict) state_d = RS_PENDING;
        RS_PENDING: if (redirect_ready_i)     state_d = RS_IDLE;
        default:                              state_d = RS_IDLE;
      endcase
    end
  end

  always_comb begin
    redirect_valid_o = 1'b0;
    fire             = 1'b0;
    ex_stall_o       = 1'b0;
    if (state_q == RS_PENDING) begin
      redirect_valid_o = 1'b1;
      fire             = redirect_ready_i;
      ex_stall_o       = ~redirect_ready_i;
    end
  end

  // redirect_pc_o only loads on a mispredicting accept, so it is stable while pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc_o   <= '0;
      backend_flush_o <= 1'b0;
    end else begin
      backend_flush_o <= accept & mispredict;
      if (accept && mispredict) begin
        redirect_pc_o <= correct_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bpu_upd_valid_o  <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      upd_target_q     <= '0;
      upd_mispredict_q <= 1'b0;
    end else begin
      bpu_upd_valid_o <= accept;
      if (accept) begin
        upd_pc_q         <= ex_pc_i;
        upd_taken_q      <= ex_taken_i;
        upd_target_q     <= ex_target_i;
        upd_mispredict_q <= mispredict;
      end
    end
  end

  assign bpu_upd_o = {upd_pc_q, upd_taken_q, upd_target_q, upd_mispredict_q};

  branch_redirect_unit_perf_counter #(
    .CNT_W (CNT_W)
  ) u_branch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept),
    .cnt (perf_branch_cnt_o)
  );

  branch_redirect_unit_perf_counter #(
    .CNT_W (CNT_W)
  ) u_mispred_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept & mispredict),
    .cnt (perf_mispred_cnt_o)
  );

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: hand-computed expectations checked with
// immediate assertions one time unit after each rising edge.
module tb_branch_redirect_unit;
  import branch_redirect_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, ex_is_branch_i, ex_taken_i, pred_taken_i;
  logic        excp_flush_i, redirect_ready_i;
  logic [31:0] ex_pc_i, ex_target_i, pred_target_i;
  logic        redirect_valid_o, backend_flush_o, ex_stall_o, bpu_upd_valid_o;
  logic [31:0] redirect_pc_o, perf_branch_cnt_o, perf_mispred_cnt_o;
  logic [65:0] bpu_upd_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_redirect_unit dut (
    .clk                (clk),
    .rst                (rst),
    .ex_valid_i         (ex_valid_i),
    .ex_is_branch_i     (ex_is_branch_i),
    .ex_pc_i            (ex_pc_i),
    .ex_taken_i         (ex_taken_i),
    .ex_target_i        (ex_target_i),
    .pred_taken_i       (pred_taken_i),
    .pred_target_i      (pred_target_i),
    .excp_flush_i       (excp_flush_i),
    .redirect_ready_i   (redirect_ready_i),
    .redirect_valid_o   (redirect_valid_o),
    .redirect_pc_o      (redirect_pc_o),
    .backend_flush_o    (backend_flush_o),
    .ex_stall_o         (ex_stall_o),
    .bpu_upd_valid_o    (bpu_upd_valid_o),
    .bpu_upd_o          (bpu_upd_o),
    .perf_branch_cnt_o  (perf_branch_cnt_o),
    .perf_mispred_cnt_o (perf_mispred_cnt_o)
  );

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    ex_valid_i     = 1'b1;
    ex_is_branch_i = 1'b1;
    ex_pc_i        = pc;
    ex_taken_i     = tk;
    ex_target_i    = tgt;
    pred_taken_i   = ptk;
    pred_target_i  = ptgt;
  endtask

  task automatic idle_in();
    ex_valid_i     = 1'b0;
    ex_is_branch_i = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input int br, input int mp);
    chk({tag, "_brcnt"}, 66'(perf_branch_cnt_o), 66'(br));
    chk({tag, "_mpcnt"}, 66'(perf_mispred_cnt_o), 66'(mp));
  endtask

  initial begin
    branch_update_t exp_upd;
    rst = 1'b1;
    excp_flush_i = 1'b0;
    redirect_ready_i = 1'b0;
    ex_pc_i = '0; ex_target_i = '0; pred_target_i = '0;
    ex_taken_i = 1'b0; pred_taken_i = 1'b0;
    idle_in();
    tick();
    tick();
    chk("rst_valid", 66'(redirect_valid_o), 66'(0));
    chk("rst_pc", 66'(redirect_pc_o), 66'(0));
    chk("rst_flush", 66'(backend_flush_o), 66'(0));
    chk("rst_bpuv", 66'(bpu_upd_valid_o), 66'(0));
    chk("rst_bpu", bpu_upd_o, 66'(0));
    chk_cnt("rst", 0, 0);
    rst = 1'b0;

    // Correctly predicted taken BEQ.
    drive_br(32'h1C00_0010, 1'b1, 32'h1C00_0040, 1'b1, 32'h1C00_0040);
    tick();
    idle_in();
    exp_upd = '{pc: 32'h1C00_0010, taken: 1'b1, target: 32'h1C00_0040, mispredict: 1'b0};
    chk("ok_bpuv", 66'(bpu_upd_valid_o), 66'(1));
    chk("ok_bpu", bpu_upd_o, exp_upd);
    chk("ok_valid", 66'(redirect_valid_o), 66'(0));
    chk("ok_flush", 66'(backend_flush_o), 66'(0));
    chk_cnt("ok", 1, 0);
    tick();
    chk("ok_bpuv_pulse", 66'(bpu_upd_valid_o), 66'(0));

    // Predicted not-taken, resolved taken.
    drive_br(32'h1C00_0020, 1'b1, 32'h1C00_0100, 1'b0, 32'h0000_0000);
    tick();
    idle_in();
    exp_upd = '{pc: 32'h1C00_0020, taken: 1'b1, target: 32'h1C00_0100, mispredict: 1'b1};
    chk("mp1_valid", 66'(redirect_valid_o), 66'(1));
    chk("mp1_pc", 66'(redirect_pc_o), 66'(32'h1C00_0100));
    chk("mp1_flush", 66'(backend_flush_o), 66'(1));
    chk("mp1_bpu", bpu_upd_o, exp_upd);
    chk("mp1_stall", 66'(ex_stall_o), 66'(1));
    chk_cnt("mp1", 2, 1);
    redirect_ready_i = 1'b1;
    #1;
    chk("mp1_fire_stall", 66'(ex_stall_o), 66'(0));
    tick();
    redirect_ready_i = 1'b0;
    chk("mp1_done_valid", 66'(redirect_valid_o), 66'(0));
    chk("mp1_flush_pulse", 66'(backend_flush_o), 66'(0));

    // Predicted taken, resolved not-taken at the top of the address space.
    drive_br(32'hFFFF_FFFC, 1'b0, 32'h1234_5678, 1'b1, 32'h1234_5678);
    tick();
    chk("wrap_pc", 66'(redirect_pc_o), 66'(0));
    chk("wrap_valid", 66'(redirect_valid_o), 66'(1));
    chk_cnt("wrap", 3, 2);

    // Hold while frontend stalls; a new mispredicting branch in EX must be ignored.
    drive_br(32'h0000_0100, 1'b1, 32'h0000_0800, 1'b0, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      chk("hold_stall", 66'(ex_stall_o), 66'(1));
      tick();
      chk("hold_valid", 66'(redirect_valid_o), 66'(1));
      chk("hold_pc", 66'(redirect_pc_o), 66'(0));
      chk("hold_flush", 66'(backend_flush_o), 66'(0));
      chk("hold_bpuv", 66'(bpu_upd_valid_o), 66'(0));
      chk_cnt("hold", 3, 2);
    end
    redirect_ready_i = 1'b1;
    idle_in();
    #1;
    chk("hold_fire_stall", 66'(ex_stall_o), 66'(0));
    tick();
    redirect_ready_i = 1'b0;
    chk("hold_done_valid", 66'(redirect_valid_o), 66'(0));

    // Branch right after the fire cycle is accepted without a bubble.
    drive_br(32'h0000_0200, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);
    tick();
    idle_in();
    exp_upd = '{pc: 32'h0000_0200, taken: 1'b0, target: 32'h0000_0000, mispredict: 1'b0};
    chk("post_bpuv", 66'(bpu_upd_valid_o), 66'(1));
    chk("post_bpu", bpu_upd_o, exp_upd);
    chk_cnt("post", 4, 2);

    // Exception flush while pending, with a branch also present.
    drive_br(32'h0000_0300, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0000);
    tick();
    chk("ex_pend_valid", 66'(redirect_valid_o), 66'(1));
    chk_cnt("ex_pend", 5, 3);
    excp_flush_i = 1'b1;
    drive_br(32'h0000_0500, 1'b1, 32'h0000_0600, 1'b0, 32'h0000_0000);
    tick();
    chk("ex_valid", 66'(redirect_valid_o), 66'(0));
    chk("ex_flush", 66'(backend_flush_o), 66'(0));
    chk("ex_bpuv", 66'(bpu_upd_valid_o), 66'(0));
    chk_cnt("ex", 5, 3);
    // Still flushing in IDLE: same-cycle branch dropped.
    tick();
    chk("ex_idle_valid", 66'(redirect_valid_o), 66'(0));
    chk("ex_idle_bpuv", 66'(bpu_upd_valid_o), 66'(0));
    chk("ex_idle_flush", 66'(backend_flush_o), 66'(0));
    chk_cnt("ex_idle", 5, 3);
    excp_flush_i = 1'b0;
    idle_in();

    // Non-branch instruction has no effect.
    drive_br(32'h0000_0700, 1'b1, 32'h0000_0900, 1'b0, 32'h0000_0000);
    ex_is_branch_i = 1'b0;
    tick();
    idle_in();
    chk("nb_bpuv", 66'(bpu_upd_valid_o), 66'(0));
    chk("nb_valid", 66'(redirect_valid_o), 66'(0));
    chk_cnt("nb", 5, 3);

    // Reset while pending.
    drive_br(32'h0000_0A00, 1'b0, 32'h0000_0B00, 1'b1, 32'h0000_0B00);
    tick();
    idle_in();
    chk("rp_valid", 66'(redirect_valid_o), 66'(1));
    chk("rp_pc", 66'(redirect_pc_o), 66'(32'h0000_0A04));
    chk_cnt("rp", 6, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rp_rst_valid", 66'(redirect_valid_o), 66'(0));
    chk("rp_rst_pc", 66'(redirect_pc_o), 66'(0));
    chk("rp_rst_flush", 66'(backend_flush_o), 66'(0));
    chk("rp_rst_stall", 66'(ex_stall_o), 66'(0));
    chk("rp_rst_bpuv", 66'(bpu_upd_valid_o), 66'(0));
    chk("rp_rst_bpu", bpu_upd_o, 66'(0));
    chk_cnt("rp_rst", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
